// File: rtl/issue_lane_reg.sv
// ID->EX register for LANES issue lanes (lane 0 oldest); 1-cycle latency, all outputs registered.
// A global stall holds every lane; per-lane kills (flush or younger-than-squash) override stall.
module issue_lane_reg #(
  parameter int LANES          = 2,
  parameter int PAYLOAD_W      = 128,
  parameter int CNT_W          = 16,
  parameter int CLEAR_ON_FLUSH = 1,
  localparam int SQ_W          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  input  logic                         stall,
  input  logic [LANES-1:0]             flush_lane,
  input  logic                         squash_valid,
  input  logic [SQ_W-1:0]              squash_lane,
  input  logic                         cnt_clr,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             kill_cnt
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LANES-1:0]     kill;
  logic [LANES-1:0]     valid_q;
  logic [PAYLOAD_W-1:0] pay_q [LANES];
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     kill_cnt_q;
  logic [PC_W-1:0]      kill_pop;
  logic [SUM_W-1:0]     kill_sum;
  logic [CNT_W-1:0]     kill_next;

  // Lane indices above squash_lane are younger than the mispredicting instruction.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam logic [SQ_W-1:0] IDX = SQ_W'(g);
    assign kill[g] = flush_lane[g] | (squash_valid & (IDX > squash_lane));
    assign out_payload[g*PAYLOAD_W +: PAYLOAD_W] = pay_q[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LANES; i++) pay_q[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (kill[i]) begin
          valid_q[i] <= 1'b0;
          if (CLEAR_ON_FLUSH != 0) pay_q[i] <= '0;
        end else if (!stall) begin
          valid_q[i] <= in_valid[i];
          pay_q[i]   <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  // Only lanes holding a live instruction count as killed.
  always_comb begin
    kill_pop = '0;
    for (int i = 0; i < LANES; i++) kill_pop = kill_pop + PC_W'(valid_q[i] & kill[i]);
    kill_sum  = SUM_W'(kill_cnt_q) + SUM_W'(kill_pop);
    kill_next = (kill_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : kill_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + 1'b1;
      kill_cnt_q <= kill_next;
    end
  end

  assign out_valid = valid_q;
  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_issue_lane_reg.sv
// Bench for issue_lane_reg: three configurations share one stimulus stream, checked against a lane-level model.
module tb_issue_lane_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_payload;
  logic        stall;
  logic [3:0]  flush_lane;
  logic        squash_valid;
  logic [1:0]  squash_lane;
  logic        cnt_clr;

  logic [1:0]  a_valid;  logic [15:0] a_pay;  logic [15:0] a_sc, a_kc;
  logic [3:0]  b_valid;  logic [31:0] b_pay;  logic [3:0]  b_sc, b_kc;
  logic [1:0]  c_valid;  logic [15:0] c_pay;  logic [3:0]  c_sc, c_kc;

  issue_lane_reg #(.LANES(2), .PAYLOAD_W(8), .CNT_W(16), .CLEAR_ON_FLUSH(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[1:0]), .in_payload(in_payload[15:0]),
    .stall(stall), .flush_lane(flush_lane[1:0]), .squash_valid(squash_valid),
    .squash_lane(squash_lane[0:0]), .cnt_clr(cnt_clr), .out_valid(a_valid),
    .out_payload(a_pay), .stall_cnt(a_sc), .kill_cnt(a_kc));

  issue_lane_reg #(.LANES(4), .PAYLOAD_W(8), .CNT_W(4), .CLEAR_ON_FLUSH(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_payload(in_payload),
    .stall(stall), .flush_lane(flush_lane), .squash_valid(squash_valid),
    .squash_lane(squash_lane), .cnt_clr(cnt_clr), .out_valid(b_valid),
    .out_payload(b_pay), .stall_cnt(b_sc), .kill_cnt(b_kc));

  issue_lane_reg #(.LANES(2), .PAYLOAD_W(8), .CNT_W(4), .CLEAR_ON_FLUSH(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[1:0]), .in_payload(in_payload[15:0]),
    .stall(stall), .flush_lane(flush_lane[1:0]), .squash_valid(squash_valid),
    .squash_lane(squash_lane[0:0]), .cnt_clr(cnt_clr), .out_valid(c_valid),
    .out_payload(c_pay), .stall_cnt(c_sc), .kill_cnt(c_kc));

  logic [3:0]  o_valid [3];
  logic [31:0] o_pay   [3];
  logic [15:0] o_sc    [3];
  logic [15:0] o_kc    [3];
  assign o_valid[0] = {2'b00, a_valid};  assign o_pay[0] = {16'h0, a_pay};
  assign o_valid[1] = b_valid;           assign o_pay[1] = b_pay;
  assign o_valid[2] = {2'b00, c_valid};  assign o_pay[2] = {16'h0, c_pay};
  assign o_sc[0] = a_sc;  assign o_kc[0] = a_kc;
  assign o_sc[1] = {12'h0, b_sc};  assign o_kc[1] = {12'h0, b_kc};
  assign o_sc[2] = {12'h0, c_sc};  assign o_kc[2] = {12'h0, c_kc};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-configuration lane contents and plain integer counters.
  logic [3:0] mv [3];
  logic [7:0] mp [3][4];
  int         msc [3];
  int         mkc [3];

  function automatic int nl(int k);   return (k == 1) ? 4 : 2;      endfunction
  function automatic int cmax(int k); return (k == 0) ? 65535 : 15; endfunction
  function automatic bit clrp(int k); return (k != 2);              endfunction

  function automatic logic [31:0] exp_pay(int k);
    logic [31:0] r = '0;
    for (int l = 0; l < nl(k); l++) r[l*8 +: 8] = mp[k][l];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = '0; msc[k] = 0; mkc[k] = 0;
      for (int l = 0; l < 4; l++) mp[k][l] = '0;
    end
  endtask

  task automatic model_step();
    int nk; int sql; bit kl;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      nk  = 0;
      sql = (nl(k) == 2) ? int'(squash_lane[0]) : int'(squash_lane);
      for (int l = 0; l < nl(k); l++) begin
        kl = flush_lane[l] || (squash_valid && (l > sql));
        if (kl) begin
          if (mv[k][l]) nk++;
          mv[k][l] = 1'b0;
          if (clrp(k)) mp[k][l] = 8'h00;
        end else if (!stall) begin
          mv[k][l] = in_valid[l];
          mp[k][l] = in_payload[l*8 +: 8];
        end
      end
      if (cnt_clr) begin
        msc[k] = 0; mkc[k] = 0;
      end else begin
        if (stall) msc[k] = (msc[k] + 1 > cmax(k)) ? cmax(k) : msc[k] + 1;
        mkc[k] = (mkc[k] + nk > cmax(k)) ? cmax(k) : mkc[k] + nk;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush_lane = '0; squash_valid = 1'b0; squash_lane = '0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({o_valid[k], o_pay[k], o_sc[k], o_kc[k]} !== 68'h0) begin
        n_err++;
        $display("FAIL reset_async k=%0d got v=%h p=%h s=%0d kc=%0d, want all zero", k, o_valid[k], o_pay[k], o_sc[k], o_kc[k]);
      end
    end
    in_valid = 4'hF; in_payload = 32'hFFFF_FFFF; stall = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({o_valid[k], o_pay[k], o_sc[k], o_kc[k]} !== 68'h0) begin
        n_err++;
        $display("FAIL reset_hold k=%0d got v=%h p=%h s=%0d kc=%0d, want all zero", k, o_valid[k], o_pay[k], o_sc[k], o_kc[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load();
    in_valid = 4'b0011; in_payload = 32'h0000_5AA5;
    tick();
    n_vec++;
    if (a_valid !== 2'b00) begin
      n_err++; $display("FAIL load_in_reset got %b want 00", a_valid);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({a_valid, a_pay} !== {2'b11, 16'h5AA5}) begin
      n_err++; $display("FAIL load_first got v=%b p=%h want v=11 p=5aa5", a_valid, a_pay);
    end
    n_vec++;
    if ({b_valid, b_pay} !== {4'b0011, 32'h0000_5AA5}) begin
      n_err++; $display("FAIL load_4lane got v=%b p=%h want v=0011 p=00005aa5", b_valid, b_pay);
    end
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; in_valid = 4'b1111; in_payload = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      flush_lane = (c == 2) ? 4'b0010 : 4'b0000;
      in_payload = in_payload + 32'h0101_0101;
      tick();
      n_vec++;
      if ({a_valid[0], a_pay[7:0]} !== {1'b1, 8'hA5}) begin
        n_err++; $display("FAIL stall_hold_lane0 cyc=%0d got v=%b p=%h want v=1 p=a5", c, a_valid[0], a_pay[7:0]);
      end
    end
    n_vec++;
    if ({a_valid, a_pay, a_sc, a_kc} !== {2'b01, 16'h00A5, 16'd3, 16'd1}) begin
      n_err++; $display("FAIL stall_flush got v=%b p=%h s=%0d kc=%0d want v=01 p=00a5 s=3 kc=1", a_valid, a_pay, a_sc, a_kc);
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({o_valid[k], o_pay[k], o_sc[k], o_kc[k]} !== {mv[k], exp_pay(k), 16'(msc[k]), 16'(mkc[k])}) begin
        n_err++;
        $display("FAIL stall_flush_model k=%0d got v=%h p=%h s=%0d kc=%0d want v=%h p=%h s=%0d kc=%0d",
                 k, o_valid[k], o_pay[k], o_sc[k], o_kc[k], mv[k], exp_pay(k), msc[k], mkc[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_squash();
    int kc0;
    in_valid = 4'b1111; in_payload = $urandom;
    tick();
    kc0 = mkc[1];
    squash_valid = 1'b1; squash_lane = 2'd1; in_payload = $urandom;
    tick();
    n_vec++;
    if ({b_valid, b_kc} !== {4'b0011, 4'(kc0 + 2)}) begin
      n_err++; $display("FAIL squash1 got v=%b kc=%0d want v=0011 kc=%0d", b_valid, b_kc, kc0 + 2);
    end
    squash_valid = 1'b0;
    tick();
    squash_valid = 1'b1; squash_lane = 2'd3;
    tick();
    n_vec++;
    if ({b_valid, b_kc} !== {4'b1111, 4'(kc0 + 2)}) begin
      n_err++; $display("FAIL squash3 got v=%b kc=%0d want v=1111 kc=%0d", b_valid, b_kc, kc0 + 2);
    end
    n_vec++;
    if (a_valid !== 2'b11) begin
      n_err++; $display("FAIL squash_2lane got v=%b want 11", a_valid);
    end
    idle_inputs();
  endtask

  task automatic test_empty_kill();
    int kc0;
    in_valid = 4'b0001;
    tick();
    kc0 = mkc[0];
    flush_lane = 4'b0010;
    tick();
    n_vec++;
    if ({a_valid, a_kc} !== {2'b01, 16'(kc0)}) begin
      n_err++; $display("FAIL empty_kill got v=%b kc=%0d want v=01 kc=%0d", a_valid, a_kc, kc0);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    stall = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    n_vec++;
    if ({b_sc, c_sc} !== 8'hFF) begin
      n_err++; $display("FAIL stall_sat got b=%0d c=%0d want 15/15", b_sc, c_sc);
    end
    n_vec++;
    if (a_sc !== 16'(msc[0])) begin
      n_err++; $display("FAIL stall_cnt16 got %0d want %0d", a_sc, msc[0]);
    end
    cnt_clr = 1'b1;
    tick();
    n_vec++;
    if ({a_sc, a_kc, b_sc, b_kc} !== 40'h0) begin
      n_err++; $display("FAIL cnt_clr got a=%0d/%0d b=%0d/%0d want all 0", a_sc, a_kc, b_sc, b_kc);
    end
    idle_inputs();
  endtask

  task automatic test_no_clear();
    in_valid = 4'b0001; in_payload = 32'h0000_0033;
    tick();
    flush_lane = 4'b0001; in_payload = 32'h0000_0077;
    tick();
    n_vec++;
    if ({c_valid[0], c_pay[7:0]} !== {1'b0, 8'h33}) begin
      n_err++; $display("FAIL no_clear got v=%b p=%h want v=0 p=33", c_valid[0], c_pay[7:0]);
    end
    n_vec++;
    if ({a_valid[0], a_pay[7:0]} !== {1'b0, 8'h00}) begin
      n_err++; $display("FAIL clear_flush got v=%b p=%h want v=0 p=00", a_valid[0], a_pay[7:0]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid     = 4'($urandom);
      in_payload   = $urandom;
      stall        = ($urandom_range(0, 3) == 0);
      flush_lane   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      squash_valid = ($urandom_range(0, 4) == 0);
      squash_lane  = 2'($urandom);
      cnt_clr      = ($urandom_range(0, 60) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if ({o_valid[k], o_pay[k], o_sc[k], o_kc[k]} !== {mv[k], exp_pay(k), 16'(msc[k]), 16'(mkc[k])}) begin
          n_err++;
          $display("FAIL random c=%0d k=%0d got v=%h p=%h s=%0d kc=%0d want v=%h p=%h s=%0d kc=%0d",
                   c, k, o_valid[k], o_pay[k], o_sc[k], o_kc[k], mv[k], exp_pay(k), msc[k], mkc[k]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    in_valid = 4'hF; in_payload = $urandom;
    tick();
    stall = 1'b1; flush_lane = 4'b0101;
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({o_valid[k], o_pay[k], o_sc[k], o_kc[k]} !== 68'h0) begin
        n_err++;
        $display("FAIL reset_mid k=%0d got v=%h p=%h s=%0d kc=%0d want all zero", k, o_valid[k], o_pay[k], o_sc[k], o_kc[k]);
      end
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    in_valid = 4'b1010; in_payload = $urandom;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({o_valid[k], o_pay[k], o_sc[k], o_kc[k]} !== {mv[k], exp_pay(k), 16'(msc[k]), 16'(mkc[k])}) begin
        n_err++;
        $display("FAIL reset_release k=%0d got v=%h p=%h s=%0d kc=%0d want v=%h p=%h s=%0d kc=%0d",
                 k, o_valid[k], o_pay[k], o_sc[k], o_kc[k], mv[k], exp_pay(k), msc[k], mkc[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_payload = '0;
    idle_inputs();
    model_reset();
    test_reset();
    test_load();
    test_stall_flush();
    test_squash();
    test_empty_kill();
    test_saturation();
    test_no_clear();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
